// File: rtl/register_file_pkg.sv
// Shared CPU definitions for the register file: widths, register count and
// the clear-sequencer state encoding.
package register_file_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned REG_COUNT = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/register_file_clear_seq.sv
// Clear sequencer: walks ClrIdx through every register after reset or a clear
// request, then holds Ready high in RUN until the next clear.
module regfile_clear_seq
  import register_file_pkg::*;
#(
  parameter int unsigned ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req,
  output state_t            state,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              ready
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          // ClrIdx wraps to 0 naturally on the same edge that writes the last index
          clr_idx <= clr_idx + ADDR_W'(1);
          if (clr_idx == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file.sv
// Eight-entry, one-write/two-read register file with write-through bypass and
// a sequenced clear that zeroes the array after reset or on request.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W = register_file_pkg::DATA_W,
  parameter int unsigned ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] ReadAddr1,
  output logic [DATA_W-1:0] ReadData1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              ClearReq,
  output logic              Ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic                user_we;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (Clk),
    .reset_n   (Reset_n),
    .clear_req (ClearReq),
    .state     (state),
    .clr_idx   (clr_idx),
    .ready     (Ready)
  );

  // A clear request in RUN wins over a same-cycle user write.
  assign user_we = (state == RUN) && WriteEnable && !ClearReq;

  always_comb begin
    we    = 1'b0;
    waddr = WriteAddr;
    wdata = WriteData;
    if (Reset_n) begin
      if (state == CLEAR) begin
        we    = 1'b1;
        waddr = clr_idx;
        wdata = '0;
      end else begin
        we = user_we;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (Ready) begin
      ReadData1 = (user_we && (WriteAddr == ReadAddr1)) ? WriteData : mem[ReadAddr1];
      ReadData2 = (user_we && (WriteAddr == ReadAddr2)) ? WriteData : mem[ReadAddr2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected Ready/ReadData
// per cycle, a monitor compares them on the falling edge.
module tb_register_file;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [2:0]  ReadAddr1, ReadAddr2, WriteAddr;
  logic [15:0] ReadData1, ReadData2, WriteData;
  logic        WriteEnable, ClearReq, Ready;

  register_file #(
    .DATA_W (16),
    .ADDR_W (3)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ReadAddr1   (ReadAddr1),
    .ReadData1   (ReadData1),
    .ReadAddr2   (ReadAddr2),
    .ReadData2   (ReadData2),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .ClearReq    (ClearReq),
    .Ready       (Ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic        rdy;
    logic [15:0] d1;
    logic [15:0] d2;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc_cnt = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] model [8];

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      while (q.size() != 0 && q[0].cyc == cyc_cnt) begin
        e = q.pop_front();
        chk({e.name, ".ready"}, {15'd0, Ready}, {15'd0, e.rdy});
        chk({e.name, ".rd1"}, ReadData1, e.d1);
        chk({e.name, ".rd2"}, ReadData2, e.d2);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic exp_out(input string name, input logic r, input logic [15:0] d1, input logic [15:0] d2);
    exp_t e;
    e.cyc  = cyc_cnt;
    e.name = name;
    e.rdy  = r;
    e.d1   = d1;
    e.d2   = d2;
    q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    WriteEnable = 1'b1; WriteAddr = a; WriteData = d;
    step();
    WriteEnable = 1'b0;
    model[a] = d;
  endtask

  task automatic expect_clear(input string name);
    for (int i = 0; i < 8; i++) begin
      exp_out(name, 1'b0, 16'h0000, 16'h0000);
      step();
    end
  endtask

  task automatic read_all(input string name);
    for (int a = 0; a < 8; a++) begin
      ReadAddr1 = 3'(a);
      ReadAddr2 = 3'(7 - a);
      exp_out(name, 1'b1, model[a], model[7 - a]);
      step();
    end
  endtask

  initial begin : stim
    Reset_n = 1'b0; ReadAddr1 = '0; ReadAddr2 = '0; WriteAddr = '0;
    WriteData = '0; WriteEnable = 1'b0; ClearReq = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;

    step();
    exp_out("reset", 1'b0, 16'h0000, 16'h0000);
    step();
    Reset_n = 1'b1;
    expect_clear("init_clear");
    read_all("init_read");

    // write then read back on both ports
    WriteEnable = 1'b1; WriteAddr = 3'd3; WriteData = 16'h1234;
    ReadAddr1 = 3'd0; ReadAddr2 = 3'd0;
    exp_out("wr_r3", 1'b1, 16'h0000, 16'h0000);
    step();
    WriteEnable = 1'b0; ReadAddr1 = 3'd3; ReadAddr2 = 3'd3;
    model[3] = 16'h1234;
    exp_out("rd_r3", 1'b1, 16'h1234, 16'h1234);
    step();

    // same-cycle bypass
    WriteEnable = 1'b1; WriteAddr = 3'd5; WriteData = 16'hBEEF;
    ReadAddr1 = 3'd5; ReadAddr2 = 3'd3;
    exp_out("bypass_r5", 1'b1, 16'hBEEF, 16'h1234);
    step();
    WriteEnable = 1'b0; ReadAddr1 = 3'd5; ReadAddr2 = 3'd5;
    model[5] = 16'hBEEF;
    exp_out("hold_r5", 1'b1, 16'hBEEF, 16'hBEEF);
    step();

    // fill, then clear request with a colliding write that must be dropped
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * (i + 1)));
    read_all("fill_read");
    ClearReq = 1'b1; WriteEnable = 1'b1; WriteAddr = 3'd2; WriteData = 16'hAAAA;
    ReadAddr1 = 3'd2; ReadAddr2 = 3'd2;
    exp_out("clr_no_bypass", 1'b1, 16'h3333, 16'h3333);
    step();
    ClearReq = 1'b0; WriteEnable = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    expect_clear("req_clear");
    read_all("req_read");

    // ClearReq and WriteEnable during CLEAR are ignored
    wr(3'd1, 16'h7777);
    ClearReq = 1'b1;
    exp_out("clr2_req", 1'b1, 16'h0000, 16'h0000);
    step();
    ClearReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_out("clr2_a", 1'b0, 16'h0000, 16'h0000);
      step();
    end
    ClearReq = 1'b1; WriteEnable = 1'b1; WriteAddr = 3'd1; WriteData = 16'h5555;
    ReadAddr1 = 3'd1;
    exp_out("clr2_idx4", 1'b0, 16'h0000, 16'h0000);
    step();
    ClearReq = 1'b0; WriteEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_out("clr2_b", 1'b0, 16'h0000, 16'h0000);
      step();
    end
    model[1] = 16'h0000;
    read_all("clr2_read");

    // reset during RUN restarts the clear and blocks a concurrent write
    wr(3'd6, 16'h6666);
    wr(3'd0, 16'h0F0F);
    ReadAddr1 = 3'd6; ReadAddr2 = 3'd0;
    exp_out("pre_reset", 1'b1, 16'h6666, 16'h0F0F);
    step();
    Reset_n = 1'b0; WriteEnable = 1'b1; WriteAddr = 3'd3; WriteData = 16'hABCD;
    step();
    Reset_n = 1'b1; WriteEnable = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    expect_clear("rst_clear");
    read_all("rst_read");

    step();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
